// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Holds default geometry, derived field widths and the controller state encoding.
// Latency/backpressure: n/a (definitions only).
package dcache_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_SETS        = 64;
  localparam int DEF_WORDS       = 4;
  localparam int DEF_MEM_LATENCY = 4;

  // Byte address = {tag, index, word offset, 2-bit byte offset}
  localparam int OFFS_W = $clog2(DEF_WORDS);
  localparam int IDX_W  = $clog2(DEF_SETS);
  localparam int TAG_W  = DEF_WIDTH - IDX_W - OFFS_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_e;

  // Tag width for a non-default geometry.
  function automatic int tag_bits(input int w, input int sets, input int words);
    return w - $clog2(sets) - $clog2(words) - 2;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Storage for the cache: per-line data words, tags and valid bits.
// Latency: combinational read, write takes effect on the next posedge.
// Backpressure: none; writes are accepted whenever enabled.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset (clears valid bits only)
//   idx             line index shared by read and write paths
//   rd_off          word offset for the read port
//   rd_valid/rd_tag/rd_word  combinational read of the indexed line
//   wr_en/wr_off/wr_data     single-word write into the indexed line
//   fill_done/fill_tag       mark the indexed line valid and store its tag
module dcache_array
  import dcache_pkg::*;
#(
  parameter int width    = DEF_WIDTH,
  parameter int SETS     = DEF_SETS,
  parameter int WORDS    = DEF_WORDS,
  parameter int IDX_BITS = $clog2(SETS),
  parameter int OFF_BITS = $clog2(WORDS),
  parameter int TAG_BITS = tag_bits(width, SETS, WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] idx,
  input  logic [OFF_BITS-1:0] rd_off,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [width-1:0]    rd_word,
  input  logic                wr_en,
  input  logic [OFF_BITS-1:0] wr_off,
  input  logic [width-1:0]    wr_data,
  input  logic                fill_done,
  input  logic [TAG_BITS-1:0] fill_tag
);

  logic [width-1:0]    data_q [SETS][WORDS];
  logic [TAG_BITS-1:0] tag_q  [SETS];
  logic [SETS-1:0]     valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (fill_done) valid_d[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Data and tags are not reset; a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en)     data_q[idx][wr_off] <= wr_data;
    if (fill_done) tag_q[idx]          <= fill_tag;
  end

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_word  = data_q[idx][rd_off];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache for the core load/store port.
// Latency: load hit 0 cycles of stall; load miss 1+WORDS*MEM_LATENCY; store MEM_LATENCY.
// Backpressure: stall holds the core; the core keeps request and operands stable while high.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cpu_re/cpu_we             load / store request (store wins)
//   cpu_addr/cpu_wdata        word-aligned byte address, store data
//   cpu_rdata                 load data, valid when cpu_re=1 and stall=0
//   stall                     hold-the-core indication
//   mem_we/mem_addr/mem_wdata Data_Memory write enable, byte address, write data
//   mem_rdata                 Data_Memory combinational read data
//   hit_count/miss_count      saturating profiling counters
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int width       = DEF_WIDTH,
  parameter int SETS        = DEF_SETS,
  parameter int WORDS       = DEF_WORDS,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [width-1:0] cpu_addr,
  input  logic [width-1:0] cpu_wdata,
  output logic [width-1:0] cpu_rdata,
  output logic             stall,
  output logic             mem_we,
  output logic [width-1:0] mem_addr,
  output logic [width-1:0] mem_wdata,
  input  logic [width-1:0] mem_rdata,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int OFF_BITS = $clog2(WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = tag_bits(width, SETS, WORDS);
  localparam int LAT_BITS = $clog2(MEM_LATENCY + 1);
  localparam logic [LAT_BITS-1:0] LAT_LAST  = LAT_BITS'(MEM_LATENCY - 1);
  localparam logic [OFF_BITS-1:0] WORD_LAST = OFF_BITS'(WORDS - 1);

  state_e              state_q, state_d;
  logic [OFF_BITS-1:0] word_cnt_q, word_cnt_d;
  logic [LAT_BITS-1:0] lat_cnt_q, lat_cnt_d;
  logic [31:0]         hit_count_q, hit_count_d;
  logic [31:0]         miss_count_q, miss_count_d;

  logic [TAG_BITS-1:0] cpu_tag;
  logic [IDX_BITS-1:0] cpu_idx;
  logic [OFF_BITS-1:0] cpu_off;

  logic                arr_valid;
  logic [TAG_BITS-1:0] arr_tag;
  logic [width-1:0]    arr_word;
  logic                arr_wr_en;
  logic [OFF_BITS-1:0] arr_wr_off;
  logic [width-1:0]    arr_wr_data;
  logic                arr_fill_done;
  logic                hit;

  assign cpu_tag = cpu_addr[width-1 -: TAG_BITS];
  assign cpu_idx = cpu_addr[2+OFF_BITS +: IDX_BITS];
  assign cpu_off = cpu_addr[2 +: OFF_BITS];
  assign hit     = arr_valid && (arr_tag == cpu_tag);

  dcache_array #(
    .width    (width),
    .SETS     (SETS),
    .WORDS    (WORDS),
    .IDX_BITS (IDX_BITS),
    .OFF_BITS (OFF_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .idx       (cpu_idx),
    .rd_off    (cpu_off),
    .rd_valid  (arr_valid),
    .rd_tag    (arr_tag),
    .rd_word   (arr_word),
    .wr_en     (arr_wr_en),
    .wr_off    (arr_wr_off),
    .wr_data   (arr_wr_data),
    .fill_done (arr_fill_done),
    .fill_tag  (cpu_tag)
  );

  // Outputs are decoded from state and the live request so a hit can return data and
  // a miss can raise stall in the same cycle the request appears. While rst is high
  // everything is forced to its idle value, which also stops a partial refill or a
  // pending write from touching the array or Data_Memory.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    stall         = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    cpu_rdata     = '0;
    arr_wr_en     = 1'b0;
    arr_wr_off    = cpu_off;
    arr_wr_data   = cpu_wdata;
    arr_fill_done = 1'b0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (cpu_we) begin
            stall     = 1'b1;
            lat_cnt_d = '0;
            state_d   = WRITE;
          end else if (cpu_re) begin
            if (hit) begin
              cpu_rdata = arr_word;
              if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
            end else begin
              stall      = 1'b1;
              lat_cnt_d  = '0;
              word_cnt_d = '0;
              state_d    = REFILL;
              if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
            end
          end
        end

        REFILL: begin
          stall    = 1'b1;
          mem_addr = {cpu_tag, cpu_idx, word_cnt_q, 2'b00};
          if (lat_cnt_q == LAT_LAST) begin
            arr_wr_en   = 1'b1;
            arr_wr_off  = word_cnt_q;
            arr_wr_data = mem_rdata;
            lat_cnt_d   = '0;
            word_cnt_d  = word_cnt_q + 1'b1;
            if (word_cnt_q == WORD_LAST) begin
              // Back in IDLE the still-held load hits and is counted there.
              arr_fill_done = 1'b1;
              state_d       = IDLE;
            end
          end else begin
            lat_cnt_d = lat_cnt_q + 1'b1;
          end
        end

        WRITE: begin
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          if (lat_cnt_q == LAT_LAST) begin
            // Release the core on the same edge the write lands; a miss leaves the line alone.
            mem_we    = 1'b1;
            arr_wr_en = hit;
            lat_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            stall     = 1'b1;
            lat_cnt_d = lat_cnt_q + 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      lat_cnt_q    <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_re     (cpu_re),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // Data_Memory model: 2048 words, combinational read, write on posedge.
  logic [31:0] dmem [0:2047];
  assign mem_rdata = dmem[mem_addr[12:2]];
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr[12:2]] = mem_wdata;
  end

  typedef struct {
    bit          is_store;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall_cycles;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];

  int checks   = 0;
  int failures = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  int we_pulses = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endfunction

  // Monitor: measures stall length per request, checks load data / store write at
  // acceptance, and checks each new refill read address against the expected list.
  int          stall_run = 0;
  logic [31:0] last_maddr = '0;
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] ra;
    if (rst) begin
      stall_run  = 0;
      last_maddr = '0;
    end else begin
      if (mem_addr[31:13] != 19'd0) chk("mem_addr_range", mem_addr, mem_addr & 32'h1FFF);
      if (cpu_re && !cpu_we && !mem_we && mem_addr != 32'd0 && mem_addr != last_maddr) begin
        if (rd_q.size() == 0) chk("unexpected_mem_read", mem_addr, 32'd0);
        else begin
          ra = rd_q.pop_front();
          chk("refill_addr", mem_addr, ra);
        end
      end
      last_maddr = mem_addr;
      if (mem_we) begin
        we_pulses++;
        if (!(cpu_we && !stall)) chk("stray_mem_we", {31'd0, mem_we}, 32'd0);
      end
      if (cpu_re || cpu_we) begin
        if (stall) stall_run++;
        else begin
          if (exp_q.size() == 0) chk("unexpected_accept", cpu_addr, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("stall_cycles", stall_run, e.stall_cycles);
            if (e.is_store) begin
              chk("st_mem_we", {31'd0, mem_we}, 32'd1);
              chk("st_mem_addr", mem_addr, e.addr);
              chk("st_mem_wdata", mem_wdata, e.data);
            end else begin
              chk("ld_rdata", cpu_rdata, e.data);
            end
          end
          stall_run = 0;
        end
      end
    end
  end

  // Issue one request; expectations are queued for the monitor. Starts and ends #1 after posedge.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] data, input bit miss);
    exp_t e;
    int   n;
    e.is_store     = we;
    e.addr         = addr;
    e.data         = data;
    e.stall_cycles = we ? 4 : (miss ? 17 : 0);
    exp_q.push_back(e);
    if (!we) begin
      exp_hits++;
      if (miss) begin
        exp_miss++;
        for (int w = 0; w < 4; w++) rd_q.push_back((addr & ~32'hF) + 32'(4 * w));
      end
    end
    cpu_re    = !we;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = we ? data : 32'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 100);
    if (stall) chk("req_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    @(negedge clk);
    chk({tag, "_hits"}, hit_count, 32'(exp_hits));
    chk({tag, "_miss"}, miss_count, 32'(exp_miss));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) dmem[i] = 32'h5A00_0000 | 32'(i);
    for (int i = 0; i < 4; i++) begin
      dmem[32'h40  + i] = 32'hA000_0000 + 32'(i);
      dmem[32'h440 + i] = 32'hB000_0000 + 32'(i);
      dmem[32'h80  + i] = 32'hC000_0000 + 32'(i);
    end
    rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    @(posedge clk); #1;

    // 1: cold miss refills line 0x100
    do_req(1'b0, 32'h100, 32'hA000_0000, 1'b1);
    go_idle();
    chk_counts("t1");

    // 2: hits in the refilled line
    do_req(1'b0, 32'h104, 32'hA000_0001, 1'b0);
    do_req(1'b0, 32'h10C, 32'hA000_0003, 1'b0);
    go_idle();
    chk_counts("t2");

    // 3: store hit, then load sees new data without a refill
    do_req(1'b1, 32'h108, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 32'h108, 32'hDEAD_BEEF, 1'b0);
    go_idle();
    chk("t3_dmem", dmem[32'h42], 32'hDEAD_BEEF);

    // 4: store miss does not allocate; following load refills and sees the stored word
    do_req(1'b1, 32'h800, 32'h1234_5678, 1'b0);
    do_req(1'b0, 32'h800, 32'h1234_5678, 1'b1);
    go_idle();
    chk_counts("t4");

    // 5: conflicting tag evicts line 0x100; reload misses and picks up the written-through word
    do_req(1'b0, 32'h1100, 32'hB000_0000, 1'b1);
    do_req(1'b0, 32'h100, 32'hA000_0000, 1'b1);
    do_req(1'b0, 32'h108, 32'hDEAD_BEEF, 1'b0);
    go_idle();
    chk_counts("t5");

    // 6: reset during refill, after word 0 landed and mid-way through word 1
    rd_q.push_back(32'h200);
    rd_q.push_back(32'h204);
    cpu_re = 1'b1; cpu_addr = 32'h200;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_stall", {31'd0, stall}, 32'd0);
    chk("t6_rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; cpu_re = 1'b0;
    exp_hits = 0; exp_miss = 0;
    chk_counts("t6_after_rst");
    do_req(1'b0, 32'h200, 32'hC000_0000, 1'b1);
    go_idle();
    chk_counts("t6_reload");

    repeat (3) @(posedge clk);
    chk("mem_we_pulses", 32'(we_pulses), 32'd2);
    chk("exp_q_left", 32'(exp_q.size()), 32'd0);
    chk("rd_q_left", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
